// File: rtl/pkt_cpu_buffer.sv
// Single-packet store-and-forward buffer with a CPU processing window.
// It captures one packet, lets the CPU edit it in place, and then drains it downstream.
module pkt_cpu_buffer #(
    parameter int DATA_WIDTH     = 64,
    parameter int CTRL_WIDTH     = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [DATA_WIDTH-1:0]            in_data,
    input  logic [CTRL_WIDTH-1:0]            in_ctrl,
    input  logic                             in_wr,
    output logic                             in_rdy,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [CTRL_WIDTH-1:0]            out_ctrl,
    output logic                             out_wr,
    input  logic                             out_rdy,
    input  logic                             cpu_bypass,
    input  logic [ADDR_WIDTH-1:0]            cpu_addr,
    input  logic [DATA_WIDTH+CTRL_WIDTH-1:0] cpu_wr_data,
    input  logic                             cpu_wen,
    output logic [DATA_WIDTH+CTRL_WIDTH-1:0] cpu_rd_data,
    input  logic                             cpu_len_wen,
    input  logic [ADDR_WIDTH:0]              cpu_len_in,
    input  logic                             cpu_done,
    output logic                             pkt_ready,
    output logic [ADDR_WIDTH:0]              pkt_len,
    output logic [2:0]                       state,
    output logic [DROP_CNT_WIDTH-1:0]        drop_count
);

    localparam int WORD_WIDTH  = DATA_WIDTH + CTRL_WIDTH;
    localparam int DEPTH_WORDS = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE = (ADDR_WIDTH + 1)'(1);
    localparam logic [DROP_CNT_WIDTH-1:0] DROP_ONE = DROP_CNT_WIDTH'(1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RECV = 3'd1,
        ST_CPU  = 3'd2,
        ST_SEND = 3'd3,
        ST_DROP = 3'd4
    } state_t;

    state_t cur_state;
    state_t next_state;

    logic [WORD_WIDTH-1:0] mem [0:DEPTH_WORDS-1];

    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic                  seen_payload;
    logic                  accept;
    logic                  is_ctrl;
    logic                  is_eop;
    logic                  room;
    logic                  drain_rd;
    logic                  drop_event;
    logic [ADDR_WIDTH:0]   len_clamped;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [WORD_WIDTH-1:0] mem_wdata;

    assign state = cur_state;

    // EOP means a ctrl word that follows payload; a second leading ctrl word is still header.
    assign accept      = in_wr & in_rdy;
    assign is_ctrl     = (in_ctrl != '0);
    assign is_eop      = accept & is_ctrl & seen_payload;
    assign room        = (count < DEPTH);
    assign drain_rd    = (cur_state == ST_SEND) & out_rdy & (rd_ptr < pkt_len);
    assign drop_event  = is_eop & ((cur_state == ST_DROP) | ((cur_state == ST_RECV) & ~room));
    assign len_clamped = (cpu_len_in > DEPTH) ? DEPTH : cpu_len_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= ST_IDLE;
        end else begin
            cur_state <= next_state;
        end
    end

    always_comb begin
        next_state = cur_state;
        case (cur_state)
            ST_IDLE: begin
                if (accept && is_ctrl) begin
                    next_state = ST_RECV;
                end
            end
            ST_RECV: begin
                if (accept) begin
                    if (room) begin
                        if (is_eop) begin
                            next_state = cpu_bypass ? ST_SEND : ST_CPU;
                        end
                    end else begin
                        next_state = is_eop ? ST_IDLE : ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                if (is_eop) begin
                    next_state = ST_IDLE;
                end
            end
            ST_CPU: begin
                if (cpu_done) begin
                    next_state = ST_SEND;
                end
            end
            ST_SEND: begin
                if (rd_ptr >= pkt_len) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        in_rdy    = 1'b0;
        pkt_ready = 1'b0;
        case (cur_state)
            ST_IDLE, ST_RECV, ST_DROP: in_rdy = 1'b1;
            ST_CPU:                    pkt_ready = 1'b1;
            default: begin
                in_rdy    = 1'b0;
                pkt_ready = 1'b0;
            end
        endcase
    end

    // The single write port is shared: the input side owns it while receiving, and the CPU owns it only in CPU.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = count[ADDR_WIDTH-1:0];
        mem_wdata = {in_ctrl, in_data};
        case (cur_state)
            ST_IDLE: begin
                if (accept && is_ctrl) begin
                    mem_we    = 1'b1;
                    mem_waddr = '0;
                end
            end
            ST_RECV: begin
                mem_we = accept & room;
            end
            ST_CPU: begin
                if (cpu_wen) begin
                    mem_we    = 1'b1;
                    mem_waddr = cpu_addr;
                    mem_wdata = cpu_wr_data;
                end
            end
            default: mem_we = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count        <= '0;
            rd_ptr       <= '0;
            pkt_len      <= '0;
            drop_count   <= '0;
            seen_payload <= 1'b0;
        end else begin
            if (cur_state != ST_SEND) begin
                rd_ptr <= '0;
            end else if (drain_rd) begin
                rd_ptr <= rd_ptr + ONE;
            end
            if (drop_event && (drop_count != '1)) begin
                drop_count <= drop_count + DROP_ONE;
            end
            case (cur_state)
                ST_IDLE: begin
                    if (accept && is_ctrl) begin
                        count        <= ONE;
                        seen_payload <= 1'b0;
                    end
                end
                ST_RECV, ST_DROP: begin
                    if (accept) begin
                        if (cur_state == ST_RECV && room) begin
                            count <= count + ONE;
                            if (is_eop) begin
                                pkt_len <= count + ONE;
                            end
                        end
                        if (!is_ctrl) begin
                            seen_payload <= 1'b1;
                        end
                    end
                end
                ST_CPU: begin
                    if (cpu_len_wen) begin
                        pkt_len <= len_clamped;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // The read port is shared too: the drain wins in SEND, and otherwise the CPU read register tracks cpu_addr.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_wr      <= 1'b0;
            out_data    <= '0;
            out_ctrl    <= '0;
            cpu_rd_data <= '0;
        end else begin
            out_wr <= drain_rd;
            if (drain_rd) begin
                {out_ctrl, out_data} <= mem[rd_ptr[ADDR_WIDTH-1:0]];
            end else begin
                cpu_rd_data <= mem[cpu_addr];
            end
        end
    end

endmodule

// File: doc/pkt_cpu_buffer.md
Name: pkt_cpu_buffer

Overview:
Single-packet store-and-forward buffer with a CPU processing window, for a NetFPGA user datapath pipeline. It captures one complete packet into internal RAM of parametrised depth, then hands it to the CPU. The CPU can read and modify any word and rewrite the packet length. The packet is then drained downstream. It adds a bypass mode, oversize-packet drop with a drop counter, CPU-programmable length, and full out_rdy backpressure.

Parameters:
DATA_WIDTH, 64, datapath data width in bits
CTRL_WIDTH, DATA_WIDTH/8, datapath ctrl width in bits
ADDR_WIDTH, 8, log2 of buffer depth; DEPTH = 2**ADDR_WIDTH words
DROP_CNT_WIDTH, 16, width of the oversize-drop counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
in_data  in  DATA_WIDTH  input word data
in_ctrl  in  CTRL_WIDTH  input word ctrl
in_wr  in  1  input word valid; only legal while in_rdy=1
in_rdy  out  1  block accepts input this cycle
out_data  out  DATA_WIDTH  output word data
out_ctrl  out  CTRL_WIDTH  output word ctrl
out_wr  out  1  output word valid
out_rdy  in  1  downstream may accept a word
cpu_bypass  in  1  sampled at EOP; 1 = skip CPU stage
cpu_addr  in  ADDR_WIDTH  CPU word address
cpu_wr_data  in  DATA_WIDTH+CTRL_WIDTH  CPU write word {ctrl,data}
cpu_wen  in  1  CPU write strobe
cpu_rd_data  out  DATA_WIDTH+CTRL_WIDTH  CPU read word {ctrl,data}
cpu_len_wen  in  1  CPU overwrites packet length
cpu_len_in  in  ADDR_WIDTH+1  new packet length in words
cpu_done  in  1  CPU finished; release packet
pkt_ready  out  1  packet held for CPU (state==CPU)
pkt_len  out  ADDR_WIDTH+1  current packet length in words
state  out  3  IDLE=0 RECV=1 CPU=2 SEND=3 DROP=4
drop_count  out  DROP_CNT_WIDTH  oversize packets dropped, saturating

Behaviour:
- Reset: sync, active-high, overrides all activity including mid-packet. state=IDLE, in_rdy=1, out_wr=0, out_data/out_ctrl=0, pkt_ready=0, pkt_len=0, drop_count=0, cpu_rd_data=0, all pointers 0. RAM contents are undefined and are discarded.
- Framing: a word with ctrl!=0 is a header or EOP; ctrl==0 is a payload word. EOP is the first ctrl!=0 word after at least one ctrl==0 word.
- in_rdy = (state==IDLE | RECV | DROP); combinational from state.
- IDLE: an accepted word with ctrl==0 is discarded. An accepted word with ctrl!=0 is written at addr 0, sets count=1, and moves to RECV.
- RECV: each accepted word is written at addr count and increments count.
  - If that word is EOP: pkt_len=count+1. Next state is SEND if cpu_bypass=1, else CPU.
  - A word arriving when count==DEPTH is not written. If it is EOP: drop_count+1 and go to IDLE. Otherwise go to DROP.
  - A packet of exactly DEPTH words fits.
- DROP: consume and discard words. On EOP: drop_count+1 (saturates at all-ones) and go to IDLE.
- CPU: pkt_ready=1.
  - cpu_wen writes cpu_wr_data to cpu_addr.
  - cpu_rd_data is RAM[cpu_addr] registered, 1-cycle latency; valid in any state and reads the last stored packet.
  - cpu_len_wen loads pkt_len from cpu_len_in; values above DEPTH clamp to DEPTH.
  - cpu_done moves to SEND. cpu_wen, cpu_len_wen and cpu_done in the same cycle: the write and the length update both take effect before SEND.
  - cpu_wen and cpu_len_wen are ignored outside CPU.
- SEND: rd_ptr starts at 0.
  - In each cycle with out_rdy=1 and rd_ptr<pkt_len, the block issues a RAM read and increments rd_ptr.
  - The matching out_wr=1 with that word's data/ctrl follows exactly 1 cycle later; out_wr is 0 otherwise.
  - out_rdy low stalls reads without losing or duplicating words.
  - The state returns to IDLE in the cycle after the last out_wr. A following packet is then accepted, with no other gap.
  - If pkt_len==0, SEND returns to IDLE next cycle with no output.
- Words leave in RAM address order 0..pkt_len-1, including any CPU modifications.
- The block is single-ported per side: the write port is shared by input and CPU writes (never concurrent by state); the read port is shared by the drain and the CPU read register, and the drain has priority in SEND.

Test Plan:
- Basic: header ctrl=0xFF, 3 payload words ctrl=0, EOP ctrl=0x0F, cpu_bypass=0 -> state=2, pkt_len=5, pkt_ready=1. Hold 10 cycles, pulse cpu_done -> 5 out_wr pulses with identical data/ctrl in order; state=0 after the last one.
- Bypass: same packet with cpu_bypass=1 at EOP -> state goes RECV->SEND; first out_wr 2 cycles after EOP accept with out_rdy=1; pkt_ready never 1.
- CPU edit: in CPU, write addr 1 = {8'h00,64'hDEADBEEF}, set cpu_len_in=3 with cpu_done in the same cycle -> exactly 3 words out, word 1 = DEADBEEF.
- Oversize: ADDR_WIDTH=3, 12-word packet -> no out_wr, drop_count=1, state=0. A following 8-word packet is forwarded intact.
- Backpressure: toggle out_rdy every other cycle during a 6-word send -> 6 out_wr total, no duplicates or gaps in sequence. Also check IDLE leading ctrl==0 junk words are discarded.
- Reset mid-RECV after 2 words -> all outputs return to reset values next cycle, drop_count=0. A new packet is then processed normally.
